imem_boot_loader: RTL and testbench

- Upstream boot block for the pipelined RISC-V core.
- Consumes a byte stream from the UART receiver and assembles little-endian 32-bit instruction words.
- Writes those words sequentially into instruction memory through a memory write port.
- Holds the core in reset until a complete, checksum-verified image has been loaded, then releases it.

---
 rtl/imem_boot_loader.sv | 146 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Function : loads a checksummed UART frame into instruction memory, then
//            releases the core from reset
// Revision : 1.0
// ============================================================================
module imem_boot_loader #(
   parameter int P_DATA_WIDTH = 32,
   parameter int P_ADDR_WIDTH = 11,
   parameter int P_TIMEOUT    = 100000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_rx_valid,
   input  logic [7:0]              i_rx_data,
   output logic                    o_imem_we,
   output logic [P_ADDR_WIDTH-1:0] o_imem_addr,
   output logic [P_DATA_WIDTH-1:0] o_imem_wdata,
   output logic                    o_core_rst_n,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_error
);

   localparam logic [2:0] c_idle   = 3'd0;
   localparam logic [2:0] c_cnt_lo = 3'd1;
   localparam logic [2:0] c_cnt_hi = 3'd2;
   localparam logic [2:0] c_data   = 3'd3;
   localparam logic [2:0] c_check  = 3'd4;
   localparam logic [2:0] c_done   = 3'd5;
   localparam logic [2:0] c_error  = 3'd6;

   localparam logic [7:0]  c_magic     = 8'hA5;
   localparam logic [16:0] c_max_words = 17'(2 ** P_ADDR_WIDTH);
   localparam int          c_tmo_w     = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(P_TIMEOUT - 1);
   localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

   logic [2:0]              r_state;
   logic [15:0]             r_count;
   logic [15:0]             r_word_idx;
   logic [1:0]              r_byte_idx;
   logic [23:0]             r_lanes;
   logic [7:0]              r_csum;
   logic [c_tmo_w-1:0]      r_tmo;
   logic                    r_we;
   logic [P_ADDR_WIDTH-1:0] r_addr;
   logic [P_DATA_WIDTH-1:0] r_wdata;

   logic [15:0] w_n;
   logic        w_last_word;
   logic        w_busy;

   assign w_n         = {i_rx_data, r_count[7:0]};
   assign w_last_word = (r_word_idx == (r_count - 16'd1));
   assign w_busy      = (r_state == c_cnt_lo) || (r_state == c_cnt_hi) ||
                        (r_state == c_data)   || (r_state == c_check);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= c_idle;
         r_count    <= '0;
         r_word_idx <= '0;
         r_byte_idx <= '0;
         r_lanes    <= '0;
         r_csum     <= '0;
         r_tmo      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            c_idle, c_error: begin
               if (i_rx_valid && (i_rx_data == c_magic)) r_state <= c_cnt_lo;
            end
            c_cnt_lo: begin
               if (i_rx_valid) begin
                  r_count[7:0] <= i_rx_data;
                  r_state      <= c_cnt_hi;
               end
            end
            c_cnt_hi: begin
               if (i_rx_valid) begin
                  r_count[15:8] <= i_rx_data;
                  if ((w_n == 16'd0) || ({1'b0, w_n} > c_max_words)) begin
                     r_state <= c_error;
                  end else begin
                     r_word_idx <= '0;
                     r_byte_idx <= '0;
                     r_csum     <= '0;
                     r_state    <= c_data;
                  end
               end
            end
            c_data: begin
               if (i_rx_valid) begin
                  r_csum     <= r_csum ^ i_rx_data;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  case (r_byte_idx)
                     2'd0: r_lanes[7:0]   <= i_rx_data;
                     2'd1: r_lanes[15:8]  <= i_rx_data;
                     2'd2: r_lanes[23:16] <= i_rx_data;
                     default: begin
                        // The 4th byte goes straight into the write register
                        r_we       <= 1'b1;
                        r_addr     <= r_word_idx[P_ADDR_WIDTH-1:0];
                        r_wdata    <= P_DATA_WIDTH'({i_rx_data, r_lanes});
                        r_word_idx <= r_word_idx + 16'd1;
                        if (w_last_word) r_state <= c_check;
                     end
                  endcase
               end
            end
            c_check: begin
               if (i_rx_valid) r_state <= (i_rx_data == r_csum) ? c_done : c_error;
            end
            c_done: r_state <= c_done;
            default: r_state <= c_idle;
         endcase

         // Inter-byte timeout only applies while a load is in flight
         if (w_busy && !i_rx_valid) begin
            if (r_tmo == c_tmo_last) begin
               r_state <= c_error;
               r_tmo   <= '0;
            end else begin
               r_tmo <= r_tmo + c_tmo_one;
            end
         end else begin
            r_tmo <= '0;
         end
      end
   end

   assign o_imem_we    = r_we;
   assign o_imem_addr  = r_addr;
   assign o_imem_wdata = r_wdata;
   assign o_busy       = w_busy;
   assign o_done       = (r_state == c_done);
   assign o_error      = (r_state == c_error);
   assign o_core_rst_n = (r_state == c_done);

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// Bench for imem_boot_loader: random frames checked against a frame-level model
// (expected writes and final status derived directly from the frame contents).
module tb_imem_boot_loader;

   localparam int c_addr_w = 11;
   localparam int c_tmo    = 300;

   logic                i_clk = 1'b0;
   logic                i_rst_n;
   logic                i_rx_valid;
   logic [7:0]          i_rx_data;
   logic                o_imem_we;
   logic [c_addr_w-1:0] o_imem_addr;
   logic [31:0]         o_imem_wdata;
   logic                o_core_rst_n;
   logic                o_busy;
   logic                o_done;
   logic                o_error;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] words[$];
   logic [42:0] wq[$];

   imem_boot_loader #(
      .P_DATA_WIDTH (32),
      .P_ADDR_WIDTH (c_addr_w),
      .P_TIMEOUT    (c_tmo)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_rx_valid   (i_rx_valid),
      .i_rx_data    (i_rx_data),
      .o_imem_we    (o_imem_we),
      .o_imem_addr  (o_imem_addr),
      .o_imem_wdata (o_imem_wdata),
      .o_core_rst_n (o_core_rst_n),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_error      (o_error)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_imem_we) wq.push_back({o_imem_addr, o_imem_wdata});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int rnd_gap(input int maxg);
      return (maxg == 0) ? 0 : int'($urandom_range(0, maxg));
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      i_rx_valid = 1'b0;
      repeat (gap) @(negedge i_clk);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      @(negedge i_clk);
      i_rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic fill_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom());
   endtask

   // Sends one frame built from 'words'; csum_xor != 0 corrupts the checksum.
   task automatic send_frame(input int n, input logic [7:0] csum_xor, input int maxg);
      logic [7:0]  cs;
      logic [7:0]  by;
      logic [15:0] nn;
      bit          ok_n;
      bit          good;
      nn   = n[15:0];
      ok_n = (n >= 1) && (n <= (1 << c_addr_w));
      good = ok_n && (csum_xor == 8'h00);
      wq.delete();
      send_byte(8'hA5, rnd_gap(maxg));
      check("busy_after_magic", 32'(o_busy), 1);
      check("error_cleared", 32'(o_error), 0);
      send_byte(nn[7:0], rnd_gap(maxg));
      send_byte(nn[15:8], rnd_gap(maxg));
      if (ok_n) begin
         cs = 8'h00;
         for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
               by = words[w][8*b +: 8];
               cs = cs ^ by;
               send_byte(by, rnd_gap(maxg));
            end
            check("we_latency", 32'(o_imem_we), 1);
            check("wr_addr", 32'(o_imem_addr), w);
            check("wr_data", o_imem_wdata, words[w]);
         end
         send_byte(cs ^ csum_xor, rnd_gap(maxg));
      end
      check("done", 32'(o_done), 32'(good));
      check("error", 32'(o_error), 32'(!good));
      check("core_rst_n", 32'(o_core_rst_n), 32'(good));
      check("busy_end", 32'(o_busy), 0);
      @(negedge i_clk);
      check("write_count", wq.size(), ok_n ? n : 0);
      if (ok_n && (wq.size() == n)) begin
         for (int i = 0; i < n; i++) begin
            check("log_addr", 32'(wq[i][42:32]), i);
            check("log_data", wq[i][31:0], words[i]);
         end
      end
   endtask

   initial begin
      i_rst_n    = 1'b0;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
      repeat (2) @(negedge i_clk);
      check("rst_we", 32'(o_imem_we), 0);
      check("rst_addr", 32'(o_imem_addr), 0);
      check("rst_wdata", o_imem_wdata, 0);
      check("rst_core", 32'(o_core_rst_n), 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_done", 32'(o_done), 0);
      check("rst_error", 32'(o_error), 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      words.delete();
      words.push_back(32'h00000013);
      words.push_back(32'h00100093);
      send_frame(2, 8'h00, 0);
      send_byte(8'hA5, 0);
      check("done_sticky", 32'(o_done), 1);
      check("magic_ignored_done", 32'(o_busy), 0);

      do_reset();
      send_frame(2, 8'h01, 1);

      words.delete();
      send_frame(0, 8'h00, 0);
      send_frame(2049, 8'h00, 1);

      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'hFF, 2);
      send_byte(8'h12, 0);
      check("garbage_ignored", 32'(o_busy), 0);
      fill_words(1);
      send_frame(1, 8'h00, 2);

      do_reset();
      wq.delete();
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      repeat (c_tmo - 10) @(negedge i_clk);
      check("tmo_not_yet", 32'(o_error), 0);
      check("tmo_busy", 32'(o_busy), 1);
      repeat (20) @(negedge i_clk);
      check("tmo_error", 32'(o_error), 1);
      check("tmo_core", 32'(o_core_rst_n), 0);
      check("tmo_nowrite", wq.size(), 0);
      fill_words(1);
      send_frame(1, 8'h00, 1);

      do_reset();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h44, 0);
      send_byte(8'h33, 0);
      #2 i_rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(o_busy), 0);
      check("midrst_core", 32'(o_core_rst_n), 0);
      check("midrst_done", 32'(o_done), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int b = 0; b < 4; b++) send_byte(8'h5A, 0);
      check("midwr_we_high", 32'(o_imem_we), 1);
      #2 i_rst_n = 1'b0;
      #1;
      check("midwr_we_drop", 32'(o_imem_we), 0);
      check("midwr_addr", 32'(o_imem_addr), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      fill_words(3);
      send_frame(3, 8'h00, 1);

      for (int i = 0; i < 8; i++) begin
         int          n;
         logic [7:0]  m;
         do_reset();
         n = int'($urandom_range(1, 6));
         m = ($urandom_range(0, 2) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'h00;
         fill_words(n);
         send_frame(n, m, 3);
      end

      do_reset();
      fill_words(1 << c_addr_w);
      send_frame(1 << c_addr_w, 8'h00, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
